mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; there are no other clock or reset inputs.
REQ-002 The ports SHALL be as listed below.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_alu_res  in  16  ALU result: memory address for loads/stores, write-back value otherwise
- in_store_data  in  16  Rt value for stores
- in_mem_rd  in  1  instruction is a load
- in_mem_wr  in  1  instruction is a store
- in_wb_en  in  1  register write-back enable
- in_wb_reg  in  3  destination register
- in_halt  in  1  instruction is HALT
- flush  in  1  discard the presented instruction
- mem_done  in  1  data memory access complete
- mem_rdata  in  16  data memory read data, valid with mem_done
- mem_en  out  1  memory request strobe
- mem_wr  out  1  request is a write
- mem_addr  out  16  request address
- mem_wdata  out  16  request write data
- stall  out  1  upstream must hold its instruction
- out_valid  out  1  write-back bundle valid
- out_wb_data  out  16  write-back data
- out_wb_reg  out  3  write-back register
- out_wb_en  out  1  write-back enable
- out_halt  out  1  retired instruction is HALT
- err  out  1  sticky error flag

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ACCESS, WAIT and HALTED.
REQ-004 stall SHALL be a function of state only: 0 in IDLE, 1 in ACCESS, WAIT and HALTED.
REQ-005 In IDLE, when in_valid=1 and flush=0, the instruction SHALL be accepted; in_valid is ignored when flush=1.
REQ-006 An accepted non-memory instruction SHALL appear on the out_* bundle with out_valid=1 on the next cycle.
- out_wb_data = in_alu_res; out_wb_reg, out_wb_en and out_halt are copied.
- Latency is 1 cycle; the FSM stays in IDLE.
REQ-007 An accepted memory instruction SHALL capture every input into holding registers and move the FSM to ACCESS.
REQ-008 ACCESS SHALL last exactly one cycle.
- mem_en=1; mem_wr = held write flag.
- mem_addr = held in_alu_res; mem_wdata = held in_store_data.
REQ-009 mem_en SHALL be 0 in every state other than ACCESS.
REQ-010 If mem_done=1 during ACCESS, the instruction SHALL complete; otherwise the FSM SHALL go to WAIT.
REQ-011 In WAIT the block SHALL hold all request outputs stable with mem_en=0 until mem_done=1, then complete.
REQ-012 Completion SHALL take effect on the next cycle:
- out_valid=1;
- out_wb_data = mem_rdata for a load, held in_alu_res for a store;
- FSM returns to IDLE, so stall falls in that same cycle.
REQ-013 out_valid SHALL pulse for exactly one cycle per retired instruction; all out_* fields hold their last values while out_valid=0.
REQ-014 mem_done SHALL be ignored in IDLE and HALTED.
REQ-015 A 9-bit watchdog SHALL clear on entering ACCESS and increment each cycle in WAIT.
- On reaching 256 without mem_done, the instruction completes with out_wb_data=0x0000 and out_wb_en=0, and err is set.
- A mem_done arriving in the cycle the count reaches 256 takes priority: normal completion, no error.
REQ-016 An instruction with in_mem_rd=1 and in_mem_wr=1 SHALL be executed as a store and SHALL set err.
REQ-017 flush SHALL be ignored in ACCESS and WAIT; an issued memory access always completes.
REQ-018 On retiring an instruction with out_halt=1, the FSM SHALL enter HALTED.
- HALTED keeps stall=1 and accepts nothing until reset.
- A HALT that is also a memory instruction enters HALTED only after its completion.
REQ-019 err SHALL be sticky and clear only on reset.

Reset
REQ-020 When rst_n=0 at a rising edge, the block SHALL, on that edge:
- set state to IDLE and clear the watchdog;
- set all outputs to 0 (mem_addr, mem_wdata and out_wb_data = 0x0000), including err;
- abandon any in-flight access with no retirement.
REQ-021 In the first cycle after rst_n rises, the block SHALL accept an instruction.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- ALU op: in_alu_res=0x1234, wb_reg=3, wb_en=1 -> next cycle out_valid=1, out_wb_data=0x1234, stall never 1.
- Load: addr 0x00F0, mem_done 3 cycles after ACCESS with rdata 0xBEEF -> mem_en high exactly 1 cycle, stall high 4 cycles, then out_wb_data=0xBEEF.
- Store: mem_done during ACCESS -> mem_wr=1, mem_wdata=in_store_data, stall high 1 cycle, out_valid the following cycle.
- Timeout: no mem_done -> after 256 WAIT cycles, out_valid=1, out_wb_data=0x0000, out_wb_en=0, err=1 until reset.
- Flush in IDLE plus a flush pulse during WAIT -> the first instruction is not retired; the in-flight access still retires.
- HALT retired, then reset asserted mid-WAIT of a following test -> stall stays 1 after HALT; reset returns all outputs to 0 and the block accepts on the first cycle after reset.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage sequencer between execute and write-back.
// Non-memory instructions retire one cycle after acceptance; loads/stores
// issue a single-cycle request (ACCESS), optionally wait for mem_done (WAIT)
// under a 9-bit watchdog, then retire. A retired HALT parks the block.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_*, flush          instruction bundle from execute
//   mem_done, mem_rdata  data memory response
//   mem_en/wr/addr/wdata data memory request
//   stall                upstream hold (high whenever not IDLE)
//   out_*                write-back bundle, out_valid pulses per retirement
//   err                  sticky error (watchdog timeout or rd+wr instruction)
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_alu_res,
  input  logic [15:0] in_store_data,
  input  logic        in_mem_rd,
  input  logic        in_mem_wr,
  input  logic        in_wb_en,
  input  logic [2:0]  in_wb_reg,
  input  logic        in_halt,
  input  logic        flush,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        stall,
  output logic        out_valid,
  output logic [15:0] out_wb_data,
  output logic [2:0]  out_wb_reg,
  output logic        out_wb_en,
  output logic        out_halt,
  output logic        err
);

  localparam int unsigned DW  = 16;
  localparam int unsigned RW  = 3;
  localparam int unsigned WDW = 9;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(256);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           wr_q, wr_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           hwb_en_q, hwb_en_d;
  logic [RW-1:0]  hwb_reg_q, hwb_reg_d;
  logic           hhalt_q, hhalt_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [RW-1:0]  out_reg_q, out_reg_d;
  logic           out_en_q, out_en_d;
  logic           out_halt_q, out_halt_d;
  logic           err_q, err_d;
  logic           complete, timeout;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wd_q        <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      hwb_en_q    <= 1'b0;
      hwb_reg_q   <= '0;
      hhalt_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_reg_q   <= '0;
      out_en_q    <= 1'b0;
      out_halt_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hwb_en_q    <= hwb_en_d;
      hwb_reg_q   <= hwb_reg_d;
      hhalt_q     <= hhalt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_reg_q   <= out_reg_d;
      out_en_q    <= out_en_d;
      out_halt_q  <= out_halt_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hwb_en_d    = hwb_en_q;
    hwb_reg_d   = hwb_reg_q;
    hhalt_d     = hhalt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_reg_d   = out_reg_q;
    out_en_d    = out_en_q;
    out_halt_d  = out_halt_q;
    err_d       = err_q;
    complete    = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          if (in_mem_rd || in_mem_wr) begin
            // A rd+wr instruction runs as a store and is flagged.
            wr_d      = in_mem_wr;
            addr_d    = in_alu_res;
            wdata_d   = in_store_data;
            hwb_en_d  = in_wb_en;
            hwb_reg_d = in_wb_reg;
            hhalt_d   = in_halt;
            wd_d      = '0;
            state_d   = ST_ACCESS;
            if (in_mem_rd && in_mem_wr) err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = in_alu_res;
            out_reg_d   = in_wb_reg;
            out_en_d    = in_wb_en;
            out_halt_d  = in_halt;
            if (in_halt) state_d = ST_HALTED;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_done) complete = 1'b1;
        else          state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // mem_done wins over the watchdog expiring in the same cycle.
        wd_d = wd_q + WDW'(1);
        if (mem_done) begin
          complete = 1'b1;
        end else if (wd_d == WD_LIMIT) begin
          complete = 1'b1;
          timeout  = 1'b1;
        end
      end
      ST_HALTED: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // Retirement of the held memory instruction.
    if (complete) begin
      out_valid_d = 1'b1;
      out_reg_d   = hwb_reg_q;
      out_halt_d  = hhalt_q;
      if (timeout) begin
        out_data_d = '0;
        out_en_d   = 1'b0;
        err_d      = 1'b1;
      end else begin
        out_data_d = wr_q ? addr_q : mem_rdata;
        out_en_d   = hwb_en_q;
      end
      state_d = hhalt_q ? ST_HALTED : ST_IDLE;
    end
  end

  // Request and status outputs decode directly from registers.
  assign mem_en      = (state_q == ST_ACCESS);
  assign stall       = (state_q != ST_IDLE);
  assign mem_wr      = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign out_valid   = out_valid_q;
  assign out_wb_data = out_data_q;
  assign out_wb_reg  = out_reg_q;
  assign out_wb_en   = out_en_q;
  assign out_halt    = out_halt_q;
  assign err         = err_q;

endmodule
